// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_pkg
// Description : Shared APB definitions: completer FSM state encoding, default
//               bus widths, and process opcodes common with the APB master.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

  // Completer transfer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } apb_state_e;

  localparam int APB_ADDR_WIDTH = 32;
  localparam int APB_DATA_WIDTH = 32;

  // Opcodes shared with apb_master_interface
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

endpackage
`default_nettype wire

// File: rtl/apb_regfile_mem.sv
`default_nettype none
// ============================================================================
// Module      : apb_regfile_mem
// Description : DEPTH x DATA_WIDTH register array with byte-enable synchronous
//               write, synchronous clear and combinational read by index.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_regfile_mem
  import apb_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = APB_DATA_WIDTH,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [IDX_W-1:0]      i_idx,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [STRB_WIDTH-1:0] i_strb,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Clear all registers on reset; otherwise update only the enabled byte lanes
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_mem[k] <= '0;
      end
    end else if (i_we) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (i_strb[b]) begin
          r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  // Combinational read port
  always_comb begin
    o_rdata = r_mem[i_idx];
  end

endmodule
`default_nettype wire

// File: rtl/apb_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module      : apb_slave_regfile
// Description : APB4 completer with DEPTH x DATA_WIDTH registers, programmable
//               wait states, byte-lane writes and registered PREADY/PRDATA.
//               Optional error response enabled by APB_SLAVE_REGFILE_PSLVERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int          ADDR_WIDTH  = APB_ADDR_WIDTH,
  parameter int          DATA_WIDTH  = APB_DATA_WIDTH,
  parameter int          STRB_WIDTH  = DATA_WIDTH / 8,
  parameter int          DEPTH       = 16,
  parameter int unsigned BASE_ADDR   = 4000,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [STRB_WIDTH-1:0] PSTRB,
  input  logic [2:0]            PPROT,
  output logic                  PREADY,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PSLVERR
);

  localparam int                    c_IDX_W     = $clog2(DEPTH);
  localparam logic [3:0]            c_WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] c_BASE      = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] c_SPAN      = ADDR_WIDTH'(DEPTH * 4);

  apb_state_e            r_state;
  apb_state_e            w_next;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_WIDTH-1:0] r_strb;

  logic                  w_setup;
  logic                  w_idle;
  logic [ADDR_WIDTH-1:0] w_cur_addr;
  logic                  w_cur_write;
  logic [DATA_WIDTH-1:0] w_cur_wdata;
  logic [STRB_WIDTH-1:0] w_cur_strb;
  logic [ADDR_WIDTH-1:0] w_offset;
  logic                  w_in_range;
  logic [c_IDX_W-1:0]    w_idx;
  logic                  w_enter_ack;
  logic                  w_err;
  logic                  w_we;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_unused;

  assign w_setup = PSEL && !PENABLE;
  assign w_idle  = (r_state == ST_IDLE);

  // A zero-wait transfer reaches ACK straight from the setup edge, before the
  // holding registers are loaded, so the live bus is used while in IDLE.
  assign w_cur_addr  = w_idle ? PADDR  : r_addr;
  assign w_cur_write = w_idle ? PWRITE : r_write;
  assign w_cur_wdata = w_idle ? PWDATA : r_wdata;
  assign w_cur_strb  = w_idle ? PSTRB  : r_strb;

  assign w_offset   = w_cur_addr - c_BASE;
  assign w_in_range = (w_offset < c_SPAN);
  assign w_idx      = w_offset[c_IDX_W+1:2];

`ifdef APB_SLAVE_REGFILE_PSLVERR_EN
  assign w_err = !w_in_range || (w_cur_write && (w_cur_strb == '0));
`else
  assign w_err = 1'b0;
`endif

  assign w_enter_ack = (w_next == ST_ACK) && (r_state != ST_ACK);
  assign w_we        = w_enter_ack && w_cur_write && w_in_range && !w_err;

  // Protection attributes and untranslated offset bits have no function here
  assign w_unused = ^{PPROT, w_offset};

  apb_regfile_mem #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .STRB_WIDTH (STRB_WIDTH),
    .IDX_W      (c_IDX_W)
  ) u_mem (
    .clk     (PCLK),
    .rst     (PRESET),
    .i_we    (w_we),
    .i_idx   (w_idx),
    .i_wdata (w_cur_wdata),
    .i_strb  (w_cur_strb),
    .o_rdata (w_rdata)
  );

  // Next-state decode: setup starts a transfer, deselect in WAIT aborts it
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_setup) w_next = (WAIT_CYCLES == 0) ? ST_ACK : ST_WAIT;
      ST_WAIT: begin
        if (!PSEL)              w_next = ST_IDLE;
        else if (r_cnt == 4'd0) w_next = ST_ACK;
      end
      ST_ACK:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge PCLK) begin
    if (PRESET) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Wait counter and capture of the request at the setup edge
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_strb  <= '0;
    end else if (w_idle && w_setup) begin
      r_cnt   <= c_WAIT_LOAD;
      r_addr  <= PADDR;
      r_write <= PWRITE;
      r_wdata <= PWDATA;
      r_strb  <= PSTRB;
    end else if ((r_state == ST_WAIT) && PSEL && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Registered response: one-cycle PREADY, read data held between reads
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      PREADY  <= 1'b0;
      PRDATA  <= '0;
      PSLVERR <= 1'b0;
    end else begin
      PREADY  <= w_enter_ack;
      PSLVERR <= w_enter_ack && w_err;
      if (w_enter_ack && !w_cur_write) begin
        PRDATA <= (w_in_range && !w_err) ? w_rdata : '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_slave_regfile
// Description : Directed self-checking bench; one completer with zero wait
//               states and one with three.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_slave_regfile;

`ifdef APB_SLAVE_REGFILE_PSLVERR_EN
  localparam logic c_ERR = 1'b1;
`else
  localparam logic c_ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  psel, penable, pwrite, pready, pslverr;
  logic [31:0] paddr  [2];
  logic [31:0] pwdata [2];
  logic [31:0] prdata [2];
  logic [3:0]  pstrb  [2];
  logic [2:0]  pprot;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  apb_slave_regfile #(.WAIT_CYCLES(0)) u_dut0 (
    .PCLK(clk), .PRESET(rst), .PSEL(psel[0]), .PENABLE(penable[0]), .PWRITE(pwrite[0]),
    .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PSTRB(pstrb[0]), .PPROT(pprot),
    .PREADY(pready[0]), .PRDATA(prdata[0]), .PSLVERR(pslverr[0])
  );

  apb_slave_regfile #(.WAIT_CYCLES(3)) u_dut3 (
    .PCLK(clk), .PRESET(rst), .PSEL(psel[1]), .PENABLE(penable[1]), .PWRITE(pwrite[1]),
    .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PSTRB(pstrb[1]), .PPROT(pprot),
    .PREADY(pready[1]), .PRDATA(prdata[1]), .PSLVERR(pslverr[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transfer; waits counts access cycles before PREADY
  task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb,
                      output logic [31:0] rd, output logic er, output int waits);
    @(negedge clk);
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
    paddr[d] = addr; pwdata[d] = data; pstrb[d] = strb;
    @(negedge clk);
    penable[d] = 1'b1;
    waits = 0;
    while (pready[d] !== 1'b1 && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    rd = prdata[d];
    er = pslverr[d];
    if (pready[d] !== 1'b1) check("timeout", {31'b0, pready[d]}, 32'd1);
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  task automatic do_write(input int d, input logic [31:0] a, input logic [31:0] v,
                          input logic [3:0] s, input int ew, input logic ee, input string tag);
    logic [31:0] rd; logic er; int w;
    xfer(d, 1'b1, a, v, s, rd, er, w);
    check({tag, " waits"}, 32'(w), 32'(ew));
    check({tag, " pslverr"}, {31'b0, er}, {31'b0, ee});
  endtask

  task automatic do_read(input int d, input logic [31:0] a, input logic [31:0] ev,
                         input int ew, input logic ee, input string tag);
    logic [31:0] rd; logic er; int w;
    xfer(d, 1'b0, a, 32'h0, 4'h0, rd, er, w);
    check({tag, " data"}, rd, ev);
    check({tag, " waits"}, 32'(w), 32'(ew));
    check({tag, " pslverr"}, {31'b0, er}, {31'b0, ee});
  endtask

  initial begin
    rst = 1'b1; psel = '0; penable = '0; pwrite = '0; pprot = 3'b010;
    for (int i = 0; i < 2; i++) begin
      paddr[i] = '0; pwdata[i] = '0; pstrb[i] = '0;
    end
    repeat (2) @(negedge clk);
    check("reset pready", {31'b0, pready[0]}, 32'd0);
    check("reset prdata", prdata[0], 32'd0);
    check("reset pslverr", {31'b0, pslverr[0]}, 32'd0);
    check("reset pready w3", {31'b0, pready[1]}, 32'd0);
    rst = 1'b0;

    // Zero-wait completer
    do_read (0, 32'd4000, 32'h0, 0, 1'b0, "rd0 after reset");
    do_write(0, 32'd4000, 32'hDEADBEEF, 4'hF, 0, 1'b0, "wr0 4000");
    do_read (0, 32'd4000, 32'hDEADBEEF, 0, 1'b0, "rd0 4000");
    do_write(0, 32'd4004, 32'h11223344, 4'hF, 0, 1'b0, "wr0 4004 full");
    do_write(0, 32'd4004, 32'hAABBCCDD, 4'b0101, 0, 1'b0, "wr0 4004 lanes");
    do_read (0, 32'd4004, 32'h11BB33DD, 0, 1'b0, "rd0 4004 lanes");
    do_write(0, 32'd4060, 32'h5A5AA5A5, 4'hF, 0, 1'b0, "wr0 last reg");
    do_read (0, 32'd4060, 32'h5A5AA5A5, 0, 1'b0, "rd0 last reg");
    do_write(0, 32'd4008, 32'h12345678, 4'h0, 0, c_ERR, "wr0 strb0");
    do_read (0, 32'd4008, 32'h0, 0, 1'b0, "rd0 strb0");
    do_write(0, 32'd4064, 32'hFFFFFFFF, 4'hF, 0, c_ERR, "wr0 out of range");
    do_read (0, 32'd4000, 32'hDEADBEEF, 0, 1'b0, "rd0 4000 after oor");
    do_read (0, 32'd4064, 32'h0, 0, c_ERR, "rd0 above range");
    do_read (0, 32'd3996, 32'h0, 0, c_ERR, "rd0 below base");

    // PENABLE without a setup phase must be ignored
    @(negedge clk);
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1;
    paddr[0] = 32'd4000; pwdata[0] = 32'h0; pstrb[0] = 4'hF;
    @(negedge clk);
    check("no setup pready a", {31'b0, pready[0]}, 32'd0);
    @(negedge clk);
    check("no setup pready b", {31'b0, pready[0]}, 32'd0);
    psel[0] = 1'b0; penable[0] = 1'b0;
    do_read (0, 32'd4000, 32'hDEADBEEF, 0, 1'b0, "rd0 after no setup");

    // Three-wait completer
    do_write(1, 32'd4000, 32'hCAFEF00D, 4'hF, 3, 1'b0, "wr3 4000");
    do_read (1, 32'd4000, 32'hCAFEF00D, 3, 1'b0, "rd3 4000");
    @(negedge clk);
    check("rd3 pready pulse", {31'b0, pready[1]}, 32'd0);

    // Abort a write while waiting
    @(negedge clk);
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = 32'd4000; pwdata[1] = 32'h12121212; pstrb[1] = 4'hF;
    @(negedge clk);
    penable[1] = 1'b1;
    check("abort pready wait", {31'b0, pready[1]}, 32'd0);
    @(negedge clk);
    psel[1] = 1'b0; penable[1] = 1'b0;
    @(negedge clk);
    check("abort pready a", {31'b0, pready[1]}, 32'd0);
    @(negedge clk);
    check("abort pready b", {31'b0, pready[1]}, 32'd0);
    do_read (1, 32'd4000, 32'hCAFEF00D, 3, 1'b0, "rd3 after abort");

    // Reset in the middle of a waited write clears everything
    @(negedge clk);
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = 32'd4004; pwdata[1] = 32'h77777777; pstrb[1] = 4'hF;
    @(negedge clk);
    penable[1] = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    psel[1] = 1'b0; penable[1] = 1'b0;
    @(negedge clk);
    check("mid reset pready", {31'b0, pready[1]}, 32'd0);
    rst = 1'b0;
    do_read (1, 32'd4000, 32'h0, 3, 1'b0, "rd3 after reset");
    do_read (1, 32'd4004, 32'h0, 3, 1'b0, "rd3 4004 after reset");
    do_read (0, 32'd4000, 32'h0, 0, 1'b0, "rd0 after reset 2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
